// File: rtl/logic_hamr_pkg.sv
// Shared constants and types for the logic-analyser capture path.
package logic_hamr_pkg;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_RISING    = 2'd1;
  localparam logic [1:0] TRIG_FALLING   = 2'd2;
  localparam logic [1:0] TRIG_EITHER    = 2'd3;

  localparam logic [12:0] CAPTURE_BASE = 13'h000;
  localparam logic [12:0] DISPLAY_BASE = 13'h200;

  localparam int NUM_SAMPLES_MAX = 266;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } cap_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Byte-wide synchronous FIFO with first-word-fall-through read; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module sample_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop && !empty && !clear;
  assign push_en = push && (!full || pop_en) && !clear;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_en) - (AW+1)'(pop_en);
    end
  end

endmodule

// File: rtl/capture_engine.sv
// Capture writer: waits for a probe trigger, samples at the divided rate and
// streams NUM_SAMPLES bytes through a small FIFO into the SDRAM capture buffer.
//
// state     | meaning
// S_IDLE    | waiting for arm
// S_ARMED   | sampling on ticks, looking for the trigger condition
// S_CAPTURE | pushing one sample per tick until NUM_SAMPLES taken
// S_DRAIN   | sampling stopped, writer emptying the FIFO
// S_DONE    | one-cycle done pulse, then back to idle
module capture_engine #(
  parameter int          NUM_SAMPLES  = logic_hamr_pkg::NUM_SAMPLES_MAX,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [12:0] CAPTURE_BASE = logic_hamr_pkg::CAPTURE_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  probe,
  input  logic        arm,
  input  logic        soft_reset,
  input  logic [7:0]  sample_div,
  input  logic [1:0]  trig_mode,
  input  logic [2:0]  trig_channel,
  output logic        busy,
  output logic        armed,
  output logic        done,
  output logic        overflow,
  output logic        sdram_wr_req,
  output logic [12:0] sdram_wr_addr,
  output logic [7:0]  sdram_wr_data,
  input  logic        sdram_wr_ready
);

  import logic_hamr_pkg::*;

  cap_state_t  state;
  logic [7:0]  div_cnt;
  logic [7:0]  div_lat;
  logic [1:0]  mode_lat;
  logic [2:0]  ch_lat;
  logic [7:0]  prev;
  logic        prev_valid;
  logic [8:0]  sample_count;
  logic [8:0]  push_cnt;
  logic [8:0]  wr_idx;

  logic        tick;
  logic        trig_hit;
  logic        writer_on;
  logic        pop;
  logic        sampling;
  logic        push;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  assign tick      = (div_cnt == 8'd0);
  assign writer_on = (state == S_ARMED) || (state == S_CAPTURE) || (state == S_DRAIN);
  assign pop       = writer_on && !sdram_wr_req && sdram_wr_ready && !fifo_empty;
  assign sampling  = tick && (((state == S_ARMED) && trig_hit) || (state == S_CAPTURE));
  assign push      = sampling && (!fifo_full || pop);

  // Edge modes never fire until a previous tick has loaded prev.
  always_comb begin
    trig_hit = 1'b0;
    case (mode_lat)
      TRIG_IMMEDIATE: trig_hit = 1'b1;
      TRIG_RISING:    trig_hit = prev_valid && !prev[ch_lat] && probe[ch_lat];
      TRIG_FALLING:   trig_hit = prev_valid && prev[ch_lat] && !probe[ch_lat];
      TRIG_EITHER:    trig_hit = prev_valid && (prev[ch_lat] != probe[ch_lat]);
      default:        trig_hit = 1'b0;
    endcase
  end

  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (soft_reset),
    .push  (push),
    .pop   (pop),
    .din   (probe),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst || soft_reset) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      div_lat       <= '0;
      mode_lat      <= '0;
      ch_lat        <= '0;
      prev          <= '0;
      prev_valid    <= 1'b0;
      sample_count  <= '0;
      push_cnt      <= '0;
      wr_idx        <= '0;
      busy          <= 1'b0;
      armed         <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      sdram_wr_req  <= 1'b0;
      sdram_wr_addr <= '0;
      sdram_wr_data <= '0;
    end else begin
      done <= 1'b0;

      if (writer_on) begin
        if (sdram_wr_req) begin
          if (sdram_wr_ready) sdram_wr_req <= 1'b0;
        end else if (pop) begin
          sdram_wr_req  <= 1'b1;
          sdram_wr_addr <= CAPTURE_BASE + {4'b0000, wr_idx};
          sdram_wr_data <= fifo_dout;
          wr_idx        <= wr_idx + 9'd1;
        end
      end

      if ((state == S_ARMED) || (state == S_CAPTURE))
        div_cnt <= tick ? div_lat : div_cnt - 8'd1;

      if (push) push_cnt <= push_cnt + 9'd1;

      case (state)
        S_IDLE: begin
          if (arm) begin
            state        <= S_ARMED;
            div_lat      <= sample_div;
            div_cnt      <= sample_div;
            mode_lat     <= trig_mode;
            ch_lat       <= trig_channel;
            overflow     <= 1'b0;
            busy         <= 1'b1;
            armed        <= 1'b1;
            sample_count <= '0;
            prev_valid   <= 1'b0;
            push_cnt     <= '0;
            wr_idx       <= '0;
          end
        end
        S_ARMED: begin
          if (tick) begin
            if (trig_hit) begin
              sample_count <= 9'd1;
              armed        <= 1'b0;
              state        <= S_CAPTURE;
            end else begin
              prev       <= probe;
              prev_valid <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (tick) begin
            if (!push) overflow <= 1'b1;
            sample_count <= sample_count + 9'd1;
            if (sample_count == 9'(NUM_SAMPLES - 1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_empty && (wr_idx == push_cnt) && !sdram_wr_req) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_engine.sv
// Randomised bench for capture_engine: records probe history each cycle and
// derives the expected trigger point and sample stream from the tick rules.
module tb_capture_engine;
  import logic_hamr_pkg::*;

  localparam int NS   = 266;
  localparam int HMAX = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  probe;
  logic        arm;
  logic        soft_reset;
  logic [7:0]  sample_div;
  logic [1:0]  trig_mode;
  logic [2:0]  trig_channel;
  logic        busy;
  logic        armed;
  logic        done;
  logic        overflow;
  logic        sdram_wr_req;
  logic [12:0] sdram_wr_addr;
  logic [7:0]  sdram_wr_data;
  logic        sdram_wr_ready;

  capture_engine dut (
    .clk            (clk),
    .rst            (rst),
    .probe          (probe),
    .arm            (arm),
    .soft_reset     (soft_reset),
    .sample_div     (sample_div),
    .trig_mode      (trig_mode),
    .trig_channel   (trig_channel),
    .busy           (busy),
    .armed          (armed),
    .done           (done),
    .overflow       (overflow),
    .sdram_wr_req   (sdram_wr_req),
    .sdram_wr_addr  (sdram_wr_addr),
    .sdram_wr_data  (sdram_wr_data),
    .sdram_wr_ready (sdram_wr_ready)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // per-cycle history; cycle n = values seen by the DUT at its n-th rising edge
  logic [7:0] probe_h [HMAX];
  logic       armed_h [HMAX];
  logic       busy_h  [HMAX];
  int         ncyc = 0;
  int         wa_q[$];
  int         wd_q[$];
  int         wc_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;

  int ppat = 0;
  int rpat = 0;
  int arm_at = 0;
  int stall_left = 0;
  bit stall_done = 0;

  initial begin
    logic        p_req;
    logic        p_rdy;
    logic        p_kill;
    logic [12:0] p_addr;
    logic [7:0]  p_data;
    p_req = 0; p_rdy = 0; p_kill = 1; p_addr = 0; p_data = 0;
    forever begin
      @(negedge clk);
      if (ncyc < HMAX) begin
        probe_h[ncyc] = probe;
        armed_h[ncyc] = armed;
        busy_h[ncyc]  = busy;
      end
      if (sdram_wr_req && sdram_wr_ready) begin
        wa_q.push_back(int'(sdram_wr_addr));
        wd_q.push_back(int'(sdram_wr_data));
        wc_q.push_back(ncyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = ncyc;
      end
      if (p_req && !p_rdy && !p_kill) begin
        chk("hold_req", sdram_wr_req, 1);
        chk("hold_addr", sdram_wr_addr, p_addr);
        chk("hold_data", sdram_wr_data, p_data);
      end
      p_req  = sdram_wr_req;
      p_rdy  = sdram_wr_ready;
      p_kill = rst || soft_reset;
      p_addr = sdram_wr_addr;
      p_data = sdram_wr_data;
      ncyc++;
    end
  end

  task automatic drive_inputs();
    int c;
    logic [7:0] r;
    c = ncyc - arm_at;
    r = 8'($urandom);
    case (ppat)
      1: probe = (c < 80) ? (r & 8'hF7) : (r | 8'h08);
      2: probe = {r[7:1], (c < 6) ? 1'b1 : 1'b0};
      3: probe = (c < 10 || c >= 24) ? (r | 8'h20) : (r & 8'hDF);
      default: probe = r;
    endcase
    if (rpat == 1) begin
      sdram_wr_ready = 1'($urandom_range(0, 1));
    end else if (rpat == 2) begin
      if (stall_left > 0) begin
        sdram_wr_ready = 1'b0;
        stall_left--;
      end else if (!stall_done && wa_q.size() >= 20 && sdram_wr_req) begin
        stall_done = 1;
        stall_left = 39;
        sdram_wr_ready = 1'b0;
      end else begin
        sdram_wr_ready = 1'b1;
      end
    end else begin
      sdram_wr_ready = 1'b1;
    end
  endtask

  task automatic cycle_once();
    @(posedge clk);
    #1;
    arm = 1'b0;
    soft_reset = 1'b0;
    drive_inputs();
  endtask

  task automatic run_cap(input string name, input int mode, input int ch, input int div,
                         input int pp, input int rp, input bit exp_ovf,
                         input bit arm_mid, input bit abort);
    int budget;
    bit aborted;
    int t, t0, n;
    bit pv, pb, cb, hit;
    aborted = 0;
    ppat = pp; rpat = rp; stall_left = 0; stall_done = 0;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    done_cnt = 0;
    cycle_once();
    arm_at = ncyc;
    arm = 1'b1;
    sample_div = 8'(div);
    trig_mode = 2'(mode);
    trig_channel = 3'(ch);
    drive_inputs();
    budget = 0;
    while (done_cnt == 0 && budget < 6000) begin
      cycle_once();
      budget++;
      if (arm_mid && ncyc == arm_at + 150) begin
        arm = 1'b1;
        sample_div = 8'(div + 3);
        trig_mode = 2'(mode ^ 1);
        trig_channel = 3'(ch + 1);
      end
      if (abort && wa_q.size() >= 100 && sdram_wr_req) begin
        soft_reset = 1'b1;
        aborted = 1;
        break;
      end
    end

    if (abort) begin
      chk({name, "_abort_reached"}, 32'(aborted), 1);
      @(posedge clk);
      #1;
      soft_reset = 1'b0;
      chk({name, "_req_dropped"}, sdram_wr_req, 0);
      chk({name, "_busy_low"}, busy, 0);
      chk({name, "_armed_low"}, armed, 0);
      repeat (20) cycle_once();
      chk({name, "_no_done"}, done_cnt, 0);
      chk({name, "_overflow"}, overflow, 0);
      return;
    end

    repeat (3) cycle_once();

    t = arm_at + 1 + div;
    t0 = -1;
    pv = 0; pb = 0;
    while (t < ncyc && t0 < 0) begin
      cb = probe_h[t][ch];
      hit = (mode == int'(TRIG_IMMEDIATE)) ||
            (pv && ((mode == int'(TRIG_RISING)  && !pb && cb) ||
                    (mode == int'(TRIG_FALLING) && pb && !cb) ||
                    (mode == int'(TRIG_EITHER)  && pb != cb)));
      if (hit) t0 = t;
      else begin
        pb = cb;
        pv = 1;
        t += div + 1;
      end
    end

    chk({name, "_trigger_found"}, 32'(t0 >= 0), 1);
    chk({name, "_done_count"}, done_cnt, 1);
    chk({name, "_overflow"}, overflow, 32'(exp_ovf));
    if (t0 < 0 || done_cnt == 0) return;
    chk({name, "_armed_at_trig"}, armed_h[t0], 1);
    chk({name, "_armed_after_trig"}, armed_h[t0 + 1], 0);
    chk({name, "_busy_at_done"}, busy_h[done_cyc], 0);
    chk({name, "_busy_before_done"}, busy_h[done_cyc - 1], 1);
    if (wc_q.size() > 0) chk({name, "_no_write_before_trig"}, 32'(wc_q[0] > t0), 1);

    n = wa_q.size();
    if (!exp_ovf) begin
      chk({name, "_write_count"}, n, NS);
      if (n > NS) n = NS;
      for (int j = 0; j < n; j++) begin
        chk({name, "_addr"}, wa_q[j], int'(CAPTURE_BASE) + j);
        chk({name, "_data"}, wd_q[j], int'(probe_h[t0 + j * (div + 1)]));
      end
    end else begin
      chk({name, "_writes_lost"}, 32'(n < NS && n >= 16), 1);
      for (int j = 0; j < n; j++) chk({name, "_addr"}, wa_q[j], int'(CAPTURE_BASE) + j);
      for (int j = 0; j < 16 && j < n; j++)
        chk({name, "_data"}, wd_q[j], int'(probe_h[t0 + j * (div + 1)]));
    end
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b1;
    soft_reset = 1'b0;
    probe = 8'hFF;
    sample_div = 8'd0;
    trig_mode = 2'd0;
    trig_channel = 3'd0;
    sdram_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_armed", armed, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_req", sdram_wr_req, 0);
    chk("rst_addr", sdram_wr_addr, 0);
    chk("rst_data", sdram_wr_data, 0);
    rst = 1'b0;
    arm = 1'b0;

    run_cap("imm",   0, 0, 1, 0, 0, 0, 0, 0);
    run_cap("rise",  1, 3, 3, 1, 0, 0, 0, 0);
    run_cap("fall",  2, 0, 1, 2, 0, 0, 0, 0);
    run_cap("supp",  1, 5, 2, 3, 0, 0, 0, 0);
    run_cap("rnd",   3, int'($urandom_range(0, 7)), 7, 0, 1, 0, 1, 0);
    run_cap("bp",    0, 0, 0, 0, 2, 1, 0, 0);
    run_cap("abort", 0, 0, 1, 0, 0, 0, 0, 1);
    run_cap("rearm", 0, 0, 2, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_engine.md
Name: capture_engine

Overview:
- Writer side of the capture buffer. After arm, waits for a trigger on the 8 probe channels.
- Once triggered, samples at a programmable rate and writes NUM_SAMPLES raw bytes to SDRAM capture buffer addresses CAPTURE_BASE..CAPTURE_BASE+NUM_SAMPLES-1.
- The regeneration engine later reads these sequentially from address 0. The trigger sample is always stored at CAPTURE_BASE.
- A small FIFO decouples the sample clock from the SDRAM write handshake.

Parameters:
- NUM_SAMPLES, 266, samples written per capture. Must cover the largest window preset.
- FIFO_DEPTH, 16, sample FIFO entries. Power of 2.
- CAPTURE_BASE, 13'h000, SDRAM address of sample 0.

Ports:
- clk  in  1  25 MHz system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- probe  in  8  probe inputs, already synchronised to clk; bit n = channel n
- arm  in  1  pulse; start capture (ignored unless idle)
- soft_reset  in  1  abort, return to idle
- sample_div  in  8  sample period = sample_div+1 clocks; latched at arm
- trig_mode  in  2  0 immediate, 1 rising, 2 falling, 3 either edge; latched at arm
- trig_channel  in  3  trigger channel; latched at arm
- busy  out  1  armed or capturing or draining
- armed  out  1  waiting for trigger
- done  out  1  one-cycle pulse when last write accepted
- overflow  out  1  sticky: a sample was dropped (FIFO full); cleared on arm/rst/soft_reset
- sdram_wr_req  out  1  write request
- sdram_wr_addr  out  13  write address
- sdram_wr_data  out  8  write data (raw probe byte)
- sdram_wr_ready  in  1  controller can accept / acknowledges request

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; counters 0.
- soft_reset has the same effect as rst except it is only effective when rst=0.
- rst/soft_reset override all other inputs in the same cycle. An in-flight sdram_wr_req is dropped immediately.
- Divider: counter reloads on arm. A tick occurs when counter==0, then the counter reloads to sample_div. With sample_div=0, a tick occurs every clock.
- States:
  - IDLE: on arm → ARMED. Latch config, clear overflow, busy=1, armed=1, sample_count=0, prev_valid=0.
  - ARMED: on each tick, evaluate trigger on the sampled probe byte.
    - Immediate: the first tick triggers.
    - Edge modes: need prev_valid=1. The first tick only loads prev.
    - rising = prev[ch]=0 & cur[ch]=1; falling is the inverse; either = either edge.
    - On trigger: push cur into the FIFO as sample 0, sample_count=1, armed=0 → CAPTURE.
    - On no trigger: prev<=cur, prev_valid=1.
  - CAPTURE: each tick pushes probe into the FIFO and increments sample_count.
    - If the FIFO is full at a tick: sample dropped, sample_count still increments, overflow=1. Addresses are then compressed; host treats data as invalid.
    - When sample_count reaches NUM_SAMPLES → DRAIN. No further sampling.
  - DRAIN: wait until the FIFO is empty and the write counter equals the pushed count, with no outstanding req → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Writer: runs concurrently in ARMED/CAPTURE/DRAIN.
  - When !sdram_wr_req & sdram_wr_ready & FIFO not empty: pop, assert req.
    - addr = CAPTURE_BASE + wr_idx (wr_idx 9-bit, zero-extended).
    - data = popped byte.
    - wr_idx++.
  - req stays high with addr/data stable until a cycle with req & ready. req clears the cycle after.
  - Minimum 2 clocks per write.
- FIFO: simultaneous push and pop when full is allowed (pop frees the slot; push accepted). Pop when empty is never issued.
- arm while busy: ignored. arm and soft_reset in the same cycle: soft_reset wins.

Decomposition:
- Package logic_hamr_pkg holds:
  - TRIG_IMMEDIATE/RISING/FALLING/EITHER constants.
  - CAPTURE_BASE=13'h000, DISPLAY_BASE=13'h200.
  - NUM_SAMPLES_MAX=266.
- Sub-module sample_fifo: synchronous FIFO, 8-bit wide, FIFO_DEPTH deep.
  - Ports: push, pop, din, dout, full, empty, clear.
  - Read is first-word-fall-through.

Test Plan:
- Immediate capture: mode 0, div=0, ready tied 1, probe = incrementing counter.
  - Expect exactly 266 writes, addr 0..265, data strictly consecutive.
  - overflow stays 0; one done pulse; busy falls with done.
- Rising trigger: mode 1, ch3, div=3, probe=0x00 for 20 ticks then 0x08.
  - Expect the first write at addr 0 with data 0x08.
  - No write before the edge; armed drops on the trigger tick.
- First-tick suppression: mode 2 (falling), ch0, probe=0x01 held at arm then 0x00 two ticks later.
  - Trigger on that falling tick only, not on the first tick.
- Backpressure: div=0, ready low for 40 cycles mid-capture.
  - req/addr/data held stable the whole time.
  - overflow=1 after the FIFO fills; capture still completes with done.
- Soft reset mid-capture: assert soft_reset after write 100 while req is high.
  - Next cycle: req=0, busy=0, no done pulse.
  - A re-arm then completes a full 266-write capture from addr 0.
- arm pulsed during CAPTURE: no effect on count, addresses or config.
